board_row_loader: RTL and testbench
===================================

Name: board_row_loader

Overview:
- Downstream consumer of the SERIAL_TO_PARALLEL shift stage.
- Accepts a serial stream of cell bits for an initial Game-of-Life board.
- Groups the bits into WIDTH-bit rows and presents each row, with its row address, over a valid/ready handshake to the grid write port.
- After HEIGHT rows it flags load complete.

Parameters:
- WIDTH, 8, cells per row (>= 2).
- HEIGHT, 8, rows per board (>= 2).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset; asynchronous, active-low.
- BIT_IN  in  1  serial cell value (1 = alive).
- BIT_VALID  in  1  BIT_IN qualifier.
- BIT_READY  out  1  loader can accept a bit this cycle.
- ABORT  in  1  synchronous restart of the board load.
- ROW_DATA  out  WIDTH  assembled row; bit WIDTH-1 = first bit received (column 0).
- ROW_ADDR  out  max(1,$clog2(HEIGHT))  row index of ROW_DATA.
- ROW_VALID  out  1  row presented.
- ROW_READY  in  1  grid accepts row.
- LOAD_DONE  out  1  all HEIGHT rows delivered.

Behaviour:
- States: FILL, PRESENT, DONE. Reset state is FILL.
- Reset values: ROW_DATA=0, ROW_ADDR=0, bit_cnt=0, ROW_VALID=0, LOAD_DONE=0, BIT_READY=1.
- BIT_READY = (state==FILL). It is decoded from state only, with no combinational path from inputs.
- A bit is accepted when BIT_VALID & BIT_READY at the rising edge.
  - Accepted bit shifts into ROW_DATA LSB; existing contents shift toward MSB.
  - bit_cnt increments on each accepted bit.
- FILL -> PRESENT on the edge accepting bit number WIDTH (bit_cnt==WIDTH-1).
  - ROW_VALID=1 immediately after that edge (zero added latency).
  - bit_cnt returns to 0 on the same edge.
- PRESENT:
  - BIT_READY=0. ROW_DATA and ROW_ADDR are held stable.
  - ROW_VALID is held until ROW_READY is sampled high.
  - Handshake edge with ROW_ADDR<HEIGHT-1: ROW_ADDR+1, ROW_VALID=0, go to FILL.
  - Handshake edge with ROW_ADDR==HEIGHT-1: ROW_VALID=0, LOAD_DONE=1, go to DONE.
- DONE:
  - BIT_READY=0, LOAD_DONE=1. BIT_VALID is ignored.
  - Exits only via ABORT or RST.
- ABORT (any state, highest synchronous priority):
  - Next edge: state=FILL, bit_cnt=0, ROW_ADDR=0, ROW_VALID=0, LOAD_DONE=0.
  - ABORT overrides a coincident bit accept or row handshake.
  - ROW_DATA is not cleared; stale content is never presented because WIDTH fresh bits precede every ROW_VALID.
- ROW_READY outside PRESENT is ignored.
- BIT_VALID held high continuously gives one accepted bit per FILL cycle and none during PRESENT or DONE.
- RST asserted mid-operation: all outputs take reset values immediately, asynchronously. A partial row is discarded.
- Counter widths:
  - bit_cnt is $clog2(WIDTH+1) bits.
  - ROW_ADDR never wraps; it saturates logically via the DONE transition.

Decomposition:
- Shared package board_loader_pkg holds:
  - loader_state_t enum {FILL, PRESENT, DONE};
  - helper constant function for ROW_ADDR width.
- Sub-module: instantiate existing SERIAL_TO_PARALLEL #(WIDTH) as the row shift register.
  - DATA_IN=BIT_IN.
  - EN=BIT_VALID & BIT_READY.
  - RST=~RST (pure async inversion, no sync logic in its reset).
  - DATA drives ROW_DATA.
- The FSM and counters live in board_row_loader.

Test Plan:
All scenarios use WIDTH=3, HEIGHT=2.
1. RST=0 for 1 ns, no clock -> ROW_DATA=000, ROW_ADDR=0, ROW_VALID=0, LOAD_DONE=0, BIT_READY=1.
2. Release RST; with BIT_VALID=0 and BIT_IN=1, run 5 clocks -> ROW_VALID=0. Then BIT_VALID=1 with bits 1,0,1 on 3 edges -> ROW_VALID=1, ROW_DATA=101, ROW_ADDR=0, BIT_READY=0.
3. Backpressure: ROW_READY=0 for 5 clocks, BIT_VALID=1, BIT_IN toggling -> ROW_DATA stays 101, ROW_VALID stays 1. Then ROW_READY=1 for 1 clock -> ROW_VALID=0, ROW_ADDR=1, BIT_READY=1.
4. Bits 0,1,1 with BIT_VALID=0 gaps between them, then handshake -> ROW_DATA=011 at ROW_ADDR=1. After the handshake: LOAD_DONE=1, BIT_READY=0. 4 further valid bits -> no change.
5. ABORT in DONE -> LOAD_DONE=0, ROW_ADDR=0, BIT_READY=1. Then 2 bits, ABORT, then bits 0,0,1 -> ROW_DATA=001, ROW_ADDR=0, ROW_VALID=1.
6. ABORT and ROW_READY both high on the same edge in PRESENT -> ROW_ADDR=0, ROW_VALID=0, state FILL. Separately, RST=0 during PRESENT -> outputs at reset values without a clock edge.

Source files
------------

// File: rtl/board_loader_pkg.sv
// Shared types and helpers for the Game-of-Life board row loader.
//   loader_state_t : FSM encoding (FILL, PRESENT, DONE)
//   row_addr_width : width of the row address bus, at least one bit
package board_loader_pkg;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    PRESENT = 2'd1,
    DONE    = 2'd2
  } loader_state_t;

  // A single-row board still needs a one-bit address bus.
  function automatic int row_addr_width(input int height);
    int w;
    w = $clog2(height);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/SERIAL_TO_PARALLEL.sv
// Serial-in / parallel-out shift register.
//   CLK     : clock, rising edge
//   RST     : asynchronous active-high reset, clears DATA
//   EN      : shift enable
//   DATA_IN : serial input, enters at the LSB
//   DATA    : register contents; the oldest bit sits at the MSB
module SERIAL_TO_PARALLEL #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             DATA_IN,
  output logic [WIDTH-1:0] DATA
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (EN) begin
      data_d = {data_q[WIDTH-2:0], DATA_IN};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign DATA = data_q;

endmodule

// File: rtl/board_row_loader.sv
// Collects a serial stream of cell bits into WIDTH-bit rows and hands each
// row, tagged with its row address, to the grid write port over valid/ready.
// After HEIGHT rows have been accepted, LOAD_DONE stays high until ABORT/RST.
//   CLK, RST          : clock, asynchronous active-low reset
//   BIT_IN/BIT_VALID  : serial cell input; BIT_READY high while filling
//   ABORT             : synchronous restart of the whole board load
//   ROW_DATA/ROW_ADDR : assembled row (column 0 at MSB) and its index
//   ROW_VALID/READY   : row handshake towards the grid
//   LOAD_DONE         : all rows delivered
module board_row_loader
  import board_loader_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic                               BIT_IN,
  input  logic                               BIT_VALID,
  output logic                               BIT_READY,
  input  logic                               ABORT,
  output logic [WIDTH-1:0]                   ROW_DATA,
  output logic [row_addr_width(HEIGHT)-1:0]  ROW_ADDR,
  output logic                               ROW_VALID,
  input  logic                               ROW_READY,
  output logic                               LOAD_DONE
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int AW = row_addr_width(HEIGHT);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [AW-1:0] LAST_ROW = AW'(HEIGHT - 1);

  loader_state_t   state_q,    state_d;
  logic [CW-1:0]   bit_cnt_q,  bit_cnt_d;
  logic [AW-1:0]   row_addr_q, row_addr_d;

  logic bit_ready;
  logic bit_accept;
  logic s2p_rst;

  // Handshake outputs are pure state decodes, so nothing from the inputs
  // reaches them combinationally.
  assign bit_ready  = (state_q == FILL);
  assign bit_accept = BIT_VALID & bit_ready;
  assign s2p_rst    = ~RST;

  // The shift register may take a bit on an ABORT edge; that is harmless
  // because a full row of fresh bits always precedes the next ROW_VALID.
  SERIAL_TO_PARALLEL #(
    .WIDTH (WIDTH)
  ) u_row_shift (
    .CLK     (CLK),
    .RST     (s2p_rst),
    .EN      (bit_accept),
    .DATA_IN (BIT_IN),
    .DATA    (ROW_DATA)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    row_addr_d = row_addr_q;

    if (ABORT) begin
      state_d    = FILL;
      bit_cnt_d  = '0;
      row_addr_d = '0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (BIT_VALID) begin
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d = '0;
              state_d   = PRESENT;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
        PRESENT: begin
          if (ROW_READY) begin
            if (row_addr_q == LAST_ROW) begin
              state_d = DONE;
            end else begin
              row_addr_d = row_addr_q + 1'b1;
              state_d    = FILL;
            end
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = FILL;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= FILL;
      bit_cnt_q  <= '0;
      row_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      row_addr_q <= row_addr_d;
    end
  end

  assign BIT_READY = bit_ready;
  assign ROW_VALID = (state_q == PRESENT);
  assign LOAD_DONE = (state_q == DONE);
  assign ROW_ADDR  = row_addr_q;

endmodule

// File: tb/tb_board_row_loader.sv
module tb_board_row_loader;

  localparam int W = 3;
  localparam int H = 2;

  logic         CLK;
  logic         RST;
  logic         BIT_IN;
  logic         BIT_VALID;
  logic         BIT_READY;
  logic         ABORT;
  logic [W-1:0] ROW_DATA;
  logic [0:0]   ROW_ADDR;
  logic         ROW_VALID;
  logic         ROW_READY;
  logic         LOAD_DONE;

  int tests_run    = 0;
  int tests_failed = 0;

  board_row_loader #(
    .WIDTH  (W),
    .HEIGHT (H)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .BIT_IN    (BIT_IN),
    .BIT_VALID (BIT_VALID),
    .BIT_READY (BIT_READY),
    .ABORT     (ABORT),
    .ROW_DATA  (ROW_DATA),
    .ROW_ADDR  (ROW_ADDR),
    .ROW_VALID (ROW_VALID),
    .ROW_READY (ROW_READY),
    .LOAD_DONE (LOAD_DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_bit(input logic b);
    BIT_VALID = 1'b1;
    BIT_IN    = b;
    step();
    BIT_VALID = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; BIT_IN = 1'b0; BIT_VALID = 1'b0; ABORT = 1'b0; ROW_READY = 1'b0;
    #1;
    RST = 1'b0;
    #1;
    tests_run++;
    if (ROW_DATA !== 3'b000 || ROW_ADDR !== 1'b0 || ROW_VALID !== 1'b0 ||
        LOAD_DONE !== 1'b0 || BIT_READY !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_values: got data=%b addr=%b valid=%b done=%b ready=%b, want 000 0 0 0 1",
               ROW_DATA, ROW_ADDR, ROW_VALID, LOAD_DONE, BIT_READY);
    end
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_first_row();
    BIT_VALID = 1'b0; BIT_IN = 1'b1;
    repeat (5) step();
    tests_run++;
    if (ROW_VALID !== 1'b0 || BIT_READY !== 1'b1) begin
      tests_failed++;
      $display("FAIL idle_no_valid: got valid=%b ready=%b, want 0 1", ROW_VALID, BIT_READY);
    end
    BIT_VALID = 1'b1;
    BIT_IN = 1'b1; step();
    BIT_IN = 1'b0; step();
    BIT_IN = 1'b1; step();
    tests_run++;
    if (ROW_VALID !== 1'b1 || ROW_DATA !== 3'b101 || ROW_ADDR !== 1'b0 || BIT_READY !== 1'b0) begin
      tests_failed++;
      $display("FAIL first_row: got valid=%b data=%b addr=%b ready=%b, want 1 101 0 0",
               ROW_VALID, ROW_DATA, ROW_ADDR, BIT_READY);
    end
  endtask

  task automatic test_backpressure();
    ROW_READY = 1'b0;
    BIT_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      BIT_IN = i[0];
      step();
      tests_run++;
      if (ROW_DATA !== 3'b101 || ROW_VALID !== 1'b1) begin
        tests_failed++;
        $display("FAIL backpressure_hold[%0d]: got data=%b valid=%b, want 101 1",
                 i, ROW_DATA, ROW_VALID);
      end
    end
    ROW_READY = 1'b1;
    step();
    ROW_READY = 1'b0;
    BIT_VALID = 1'b0;
    $display("[TB] row handshake addr=0 data=101");
    tests_run++;
    if (ROW_VALID !== 1'b0 || ROW_ADDR !== 1'b1 || BIT_READY !== 1'b1) begin
      tests_failed++;
      $display("FAIL handshake_row0: got valid=%b addr=%b ready=%b, want 0 1 1",
               ROW_VALID, ROW_ADDR, BIT_READY);
    end
  endtask

  task automatic test_second_row_done();
    send_bit(1'b0); step();
    send_bit(1'b1); step();
    send_bit(1'b1);
    tests_run++;
    if (ROW_VALID !== 1'b1 || ROW_DATA !== 3'b011 || ROW_ADDR !== 1'b1) begin
      tests_failed++;
      $display("FAIL second_row: got valid=%b data=%b addr=%b, want 1 011 1",
               ROW_VALID, ROW_DATA, ROW_ADDR);
    end
    ROW_READY = 1'b1;
    step();
    ROW_READY = 1'b0;
    $display("[TB] row handshake addr=1 data=011");
    tests_run++;
    if (LOAD_DONE !== 1'b1 || BIT_READY !== 1'b0 || ROW_VALID !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_done: got done=%b ready=%b valid=%b, want 1 0 0",
               LOAD_DONE, BIT_READY, ROW_VALID);
    end
    BIT_VALID = 1'b1;
    for (int i = 0; i < 4; i++) begin
      BIT_IN = ~i[0];
      step();
    end
    BIT_VALID = 1'b0;
    tests_run++;
    if (LOAD_DONE !== 1'b1 || BIT_READY !== 1'b0 || ROW_VALID !== 1'b0 ||
        ROW_ADDR !== 1'b1 || ROW_DATA !== 3'b011) begin
      tests_failed++;
      $display("FAIL done_ignores_bits: got done=%b ready=%b valid=%b addr=%b data=%b, want 1 0 0 1 011",
               LOAD_DONE, BIT_READY, ROW_VALID, ROW_ADDR, ROW_DATA);
    end
  endtask

  task automatic test_abort();
    ABORT = 1'b1; step(); ABORT = 1'b0;
    tests_run++;
    if (LOAD_DONE !== 1'b0 || ROW_ADDR !== 1'b0 || BIT_READY !== 1'b1 || ROW_VALID !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_in_done: got done=%b addr=%b ready=%b valid=%b, want 0 0 1 0",
               LOAD_DONE, ROW_ADDR, BIT_READY, ROW_VALID);
    end
    send_bit(1'b1);
    send_bit(1'b1);
    ABORT = 1'b1; step(); ABORT = 1'b0;
    send_bit(1'b0);
    send_bit(1'b0);
    tests_run++;
    if (ROW_VALID !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_clears_count: got valid=%b after 2 fresh bits, want 0", ROW_VALID);
    end
    send_bit(1'b1);
    tests_run++;
    if (ROW_DATA !== 3'b001 || ROW_ADDR !== 1'b0 || ROW_VALID !== 1'b1) begin
      tests_failed++;
      $display("FAIL row_after_abort: got data=%b addr=%b valid=%b, want 001 0 1",
               ROW_DATA, ROW_ADDR, ROW_VALID);
    end
  endtask

  task automatic test_abort_priority_and_async_reset();
    ABORT = 1'b1; ROW_READY = 1'b1;
    step();
    ABORT = 1'b0; ROW_READY = 1'b0;
    tests_run++;
    if (ROW_ADDR !== 1'b0 || ROW_VALID !== 1'b0 || BIT_READY !== 1'b1 || LOAD_DONE !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_beats_handshake: got addr=%b valid=%b ready=%b done=%b, want 0 0 1 0",
               ROW_ADDR, ROW_VALID, BIT_READY, LOAD_DONE);
    end
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    tests_run++;
    if (ROW_VALID !== 1'b1 || ROW_DATA !== 3'b110) begin
      tests_failed++;
      $display("FAIL refill_before_rst: got valid=%b data=%b, want 1 110", ROW_VALID, ROW_DATA);
    end
    #2;
    RST = 1'b0;
    #1;
    tests_run++;
    if (ROW_DATA !== 3'b000 || ROW_ADDR !== 1'b0 || ROW_VALID !== 1'b0 ||
        LOAD_DONE !== 1'b0 || BIT_READY !== 1'b1) begin
      tests_failed++;
      $display("FAIL async_rst_in_present: got data=%b addr=%b valid=%b done=%b ready=%b, want 000 0 0 0 1",
               ROW_DATA, ROW_ADDR, ROW_VALID, LOAD_DONE, BIT_READY);
    end
    @(negedge CLK);
    RST = 1'b1;
    step();
  endtask

  // Reference model: bits of the current row are kept in a queue; a row is
  // on offer exactly when the queue holds W bits.
  task automatic test_random();
    logic q_bits[$];
    int   m_addr;
    bit   m_done;
    bit   m_present;
    int   exp_data;
    logic v, b, rr, ab;

    q_bits.delete();
    m_addr = 0;
    m_done = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      v  = ($urandom_range(0, 9) < 7);
      b  = 1'($urandom_range(0, 1));
      rr = ($urandom_range(0, 1) == 1);
      ab = ($urandom_range(0, 39) == 0);
      BIT_VALID = v; BIT_IN = b; ROW_READY = rr; ABORT = ab;

      m_present = (q_bits.size() == W);
      if (ab) begin
        q_bits.delete();
        m_addr = 0;
        m_done = 0;
      end else if (m_done) begin
        // nothing moves once the board is loaded
      end else if (m_present) begin
        if (rr) begin
          exp_data = 0;
          foreach (q_bits[k]) exp_data = exp_data * 2 + int'(q_bits[k]);
          $display("[TB] row handshake addr=%0d data=%03b", m_addr, exp_data[W-1:0]);
          q_bits.delete();
          if (m_addr == H - 1) m_done = 1;
          else m_addr++;
        end
      end else if (v) begin
        q_bits.push_back(b);
      end

      step();

      m_present = (q_bits.size() == W);
      tests_run++;
      if (ROW_VALID !== m_present || BIT_READY !== (!m_present && !m_done) ||
          LOAD_DONE !== m_done || int'(ROW_ADDR) != m_addr) begin
        tests_failed++;
        $display("FAIL random_ctrl[%0d]: got valid=%b ready=%b done=%b addr=%0d, want %b %b %b %0d",
                 cyc, ROW_VALID, BIT_READY, LOAD_DONE, ROW_ADDR,
                 m_present, (!m_present && !m_done), m_done, m_addr);
      end
      if (m_present) begin
        exp_data = 0;
        foreach (q_bits[k]) exp_data = exp_data * 2 + int'(q_bits[k]);
        tests_run++;
        if (ROW_DATA !== exp_data[W-1:0]) begin
          tests_failed++;
          $display("FAIL random_data[%0d]: got %b, want %b", cyc, ROW_DATA, exp_data[W-1:0]);
        end
      end
    end
    BIT_VALID = 1'b0; ROW_READY = 1'b0; ABORT = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_row();
    test_backpressure();
    test_second_row_done();
    test_abort();
    test_abort_priority_and_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
